// File: rtl/spart_tx_sched.sv
// Round-robin byte arbiter and bus-cycle generator in front of the SPART transmitter.
// Optional SPART_TX_STATS_EN adds a 16-bit count of issued data bytes (tx_count).
module spart_tx_sched #(
  parameter int unsigned NREQ        = 4,
  parameter logic [15:0] DIV_DEFAULT = 16'd325
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  input  logic              cfg_load,
  input  logic [15:0]       cfg_div,
  output logic              cfg_busy,
  input  logic              tbr,
  output logic              iocs,
  output logic              iorw,
  output logic [1:0]        ioaddr,
  output logic [7:0]        databus
`ifdef SPART_TX_STATS_EN
  ,
  output logic [15:0]       tx_count
`endif
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, CFG_LO, CFG_HI, WRITE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q, win_q, win_idx;
  logic             found;
  logic [7:0]       win_byte;
  int unsigned      scan_idx;
  logic [15:0]      div_q;
  logic             pending_q, redo_q, boot_q;

  logic             iocs_d, iorw_d;
  logic [1:0]       ioaddr_d;
  logic [7:0]       databus_d;
  logic [NREQ-1:0]  gnt_d;

  // Round-robin search starting at the pointer, wrapping at NREQ-1.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    scan_idx = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = 32'(ptr_q) + k;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      if (!found && req[IW'(scan_idx)]) begin
        found   = 1'b1;
        win_idx = IW'(scan_idx);
      end
    end
  end

  always_comb begin
    win_byte = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_idx == IW'(i)) win_byte = req_data[8*i +: 8];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= CFG_LO;
    else      state_q <= state_d;
  end

  // Next state; the first CFG_LO after reset holds one extra cycle to issue the low byte.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (tbr && pending_q)  state_d = CFG_LO;
        else if (tbr && found) state_d = WRITE;
      end
      CFG_LO:  state_d = boot_q ? CFG_LO : CFG_HI;
      CFG_HI:  state_d = IDLE;
      WRITE:   state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus values for the cycle in which the FSM sits in state_d.
  always_comb begin
    iocs_d    = 1'b0;
    iorw_d    = 1'b1;
    ioaddr_d  = 2'd0;
    databus_d = 8'd0;
    gnt_d     = '0;
    unique case (state_d)
      CFG_LO: begin
        iocs_d    = 1'b1;
        iorw_d    = 1'b0;
        ioaddr_d  = 2'd2;
        databus_d = div_q[7:0];
      end
      CFG_HI: begin
        iocs_d    = 1'b1;
        iorw_d    = 1'b0;
        ioaddr_d  = 2'd3;
        databus_d = div_q[15:8];
      end
      WRITE: begin
        iocs_d         = 1'b1;
        iorw_d         = 1'b0;
        ioaddr_d       = 2'd0;
        databus_d      = win_byte;
        gnt_d[win_idx] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iocs    <= 1'b0;
      iorw    <= 1'b1;
      ioaddr  <= 2'd0;
      databus <= 8'd0;
      gnt     <= '0;
    end else begin
      iocs    <= iocs_d;
      iorw    <= iorw_d;
      ioaddr  <= ioaddr_d;
      databus <= databus_d;
      gnt     <= gnt_d;
    end
  end

  // Arbitration bookkeeping and divisor latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q     <= '0;
      win_q     <= '0;
      div_q     <= DIV_DEFAULT;
      pending_q <= 1'b1;
      redo_q    <= 1'b0;
      boot_q    <= 1'b1;
    end else begin
      boot_q <= 1'b0;
      if (state_q == IDLE && state_d == WRITE) win_q <= win_idx;
      if (state_q == WRITE) ptr_q <= (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
      if (cfg_load) div_q <= cfg_div;
      // A reload that lands while the low byte is being issued forces a full repeat.
      if (state_q == CFG_HI) begin
        pending_q <= cfg_load | redo_q;
        redo_q    <= 1'b0;
      end else begin
        if (cfg_load) pending_q <= 1'b1;
        if (cfg_load && (state_q == CFG_LO || state_d == CFG_LO)) redo_q <= 1'b1;
      end
    end
  end

  assign cfg_busy = pending_q;

`ifdef SPART_TX_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   tx_count <= 16'd0;
    else if (state_q == WRITE) tx_count <= tx_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_spart_tx_sched.sv
// Directed bench for spart_tx_sched: per-cycle vector table plus reset/round-robin sequences.
module tb_spart_tx_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        cfg_load;
  logic [15:0] cfg_div;
  logic        cfg_busy;
  logic        tbr;
  logic        iocs, iorw;
  logic [1:0]  ioaddr;
  logic [7:0]  databus;
`ifdef SPART_TX_STATS_EN
  logic [15:0] tx_count;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  spart_tx_sched #(.NREQ(4), .DIV_DEFAULT(16'd325)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .cfg_load (cfg_load),
    .cfg_div  (cfg_div),
    .cfg_busy (cfg_busy),
    .tbr      (tbr),
    .iocs     (iocs),
    .iorw     (iorw),
    .ioaddr   (ioaddr),
    .databus  (databus)
`ifdef SPART_TX_STATS_EN
    ,
    .tx_count (tx_count)
`endif
  );

  typedef struct {
    logic        rst;
    logic        tbr;
    logic [3:0]  req;
    logic [31:0] rd;
    logic        cl;
    logic [15:0] cd;
    logic [16:0] exp; // {iocs, iorw, ioaddr, databus, gnt, cfg_busy}
  } vec_t;

  localparam int NV = 34;
  vec_t vt [NV];

  function automatic vec_t mk(input logic r, input logic t, input logic [3:0] q,
                              input logic [31:0] d, input logic l, input logic [15:0] c,
                              input logic o, input logic w, input logic [1:0] a,
                              input logic [7:0] b, input logic [3:0] g, input logic y);
    vec_t v;
    v.rst = r; v.tbr = t; v.req = q; v.rd = d; v.cl = l; v.cd = c;
    v.exp = {o, w, a, b, g, y};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (gnt != 4'd0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    // rst tbr req rd cl cd | iocs iorw addr data gnt busy
    vt[0]  = mk(0,1,4'h0,32'h0,0,16'h0,      0,1,0,8'h00,4'h0,1);
    vt[1]  = mk(1,1,4'h0,32'h0,0,16'h0,      1,0,2,8'h45,4'h0,1);
    vt[2]  = mk(1,1,4'h0,32'h0,0,16'h0,      1,0,3,8'h01,4'h0,1);
    vt[3]  = mk(1,1,4'h0,32'h0,0,16'h0,      0,1,0,8'h00,4'h0,0);
    vt[4]  = mk(1,1,4'h0,32'h0,0,16'h0,      0,1,0,8'h00,4'h0,0);
    vt[5]  = mk(1,1,4'h1,32'hA5,0,16'h0,     1,0,0,8'hA5,4'h1,0);
    vt[6]  = mk(1,0,4'h0,32'h0,0,16'h0,      0,1,0,8'h00,4'h0,0);
    vt[7]  = mk(1,0,4'h1,32'h5A,0,16'h0,     0,1,0,8'h00,4'h0,0);
    vt[8]  = mk(1,0,4'h1,32'h5A,0,16'h0,     0,1,0,8'h00,4'h0,0);
    vt[9]  = mk(1,0,4'h1,32'h5A,0,16'h0,     0,1,0,8'h00,4'h0,0);
    vt[10] = mk(1,1,4'h1,32'h5A,0,16'h0,     1,0,0,8'h5A,4'h1,0);
    vt[11] = mk(1,0,4'h0,32'h0,0,16'h0,      0,1,0,8'h00,4'h0,0);
    vt[12] = mk(1,0,4'h0,32'h0,0,16'h0,      0,1,0,8'h00,4'h0,0);
    vt[13] = mk(1,0,4'h4,32'h00770000,1,16'h0010, 0,1,0,8'h00,4'h0,1);
    vt[14] = mk(1,0,4'h4,32'h00770000,0,16'h0,    0,1,0,8'h00,4'h0,1);
    vt[15] = mk(1,1,4'h4,32'h00770000,0,16'h0,    1,0,2,8'h10,4'h0,1);
    vt[16] = mk(1,1,4'h4,32'h00770000,0,16'h0,    1,0,3,8'h00,4'h0,1);
    vt[17] = mk(1,1,4'h4,32'h00770000,0,16'h0,    0,1,0,8'h00,4'h0,0);
    vt[18] = mk(1,1,4'h4,32'h00770000,0,16'h0,    1,0,0,8'h77,4'h4,0);
    vt[19] = mk(1,0,4'h0,32'h0,0,16'h0,      0,1,0,8'h00,4'h0,0);
    vt[20] = mk(1,0,4'h0,32'h0,0,16'h0,      0,1,0,8'h00,4'h0,0);
    vt[21] = mk(1,1,4'h2,32'h00003C00,1,16'h1234, 1,0,0,8'h3C,4'h2,1);
    vt[22] = mk(1,0,4'h0,32'h0,0,16'h0,      0,1,0,8'h00,4'h0,1);
    vt[23] = mk(1,1,4'h0,32'h0,0,16'h0,      0,1,0,8'h00,4'h0,1);
    vt[24] = mk(1,1,4'h0,32'h0,0,16'h0,      1,0,2,8'h34,4'h0,1);
    vt[25] = mk(1,1,4'h0,32'h0,0,16'h0,      1,0,3,8'h12,4'h0,1);
    vt[26] = mk(1,1,4'h0,32'h0,0,16'h0,      0,1,0,8'h00,4'h0,0);
    vt[27] = mk(1,1,4'h0,32'h0,1,16'hABCD,   0,1,0,8'h00,4'h0,1);
    vt[28] = mk(1,1,4'h0,32'h0,0,16'h0,      1,0,2,8'hCD,4'h0,1);
    vt[29] = mk(1,1,4'h0,32'h0,1,16'h5678,   1,0,3,8'hAB,4'h0,1);
    vt[30] = mk(1,1,4'h0,32'h0,0,16'h0,      0,1,0,8'h00,4'h0,1);
    vt[31] = mk(1,1,4'h0,32'h0,0,16'h0,      1,0,2,8'h78,4'h0,1);
    vt[32] = mk(1,1,4'h0,32'h0,0,16'h0,      1,0,3,8'h56,4'h0,1);
    vt[33] = mk(1,1,4'h0,32'h0,0,16'h0,      0,1,0,8'h00,4'h0,0);

    rst = 1'b1; req = '0; req_data = '0; cfg_load = 1'b0; cfg_div = '0; tbr = 1'b1;
    #1 rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = vt[i].rst; tbr = vt[i].tbr; req = vt[i].req; req_data = vt[i].rd;
      cfg_load = vt[i].cl; cfg_div = vt[i].cd;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), 32'({iocs, iorw, ioaddr, databus, gnt, cfg_busy}),
          32'(vt[i].exp));
    end

    // Async reset in the middle of a data write (pointer is 2 here).
    @(negedge clk);
    cfg_load = 1'b0; req = 4'hF; req_data = 32'h44332211; tbr = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_gnt", 32'({gnt, databus}), 32'({4'h4, 8'h33}));
    #2 rst = 1'b0;
    #1;
    chk("rst_async_bus", 32'({iocs, iorw, gnt, cfg_busy}), 32'({1'b0, 1'b1, 4'h0, 1'b1}));
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_cfg_lo", 32'({iocs, ioaddr, databus}), 32'({1'b1, 2'd2, 8'h45}));
    @(posedge clk); #1;
    chk("rst_cfg_hi", 32'({iocs, ioaddr, databus}), 32'({1'b1, 2'd3, 8'h01}));
`ifdef SPART_TX_STATS_EN
    chk("stats_rst", 32'(tx_count), 32'd0);
`endif

    // All four requesting: grants rotate from requester 0.
    for (int g = 0; g < 5; g++) begin
      wait_gnt(ok);
      chk($sformatf("rr_wait%0d", g), 32'(ok), 32'd1);
      chk($sformatf("rr_gnt%0d", g), 32'(gnt), 32'(4'b0001 << (g % 4)));
      chk($sformatf("rr_data%0d", g), 32'(databus), 32'(8'h11 * (g % 4 + 1)));
      @(negedge clk);
      tbr = 1'b0;
      if (g == 4) req = 4'h0;
      @(negedge clk);
      tbr = 1'b1;
    end

`ifdef SPART_TX_STATS_EN
    @(posedge clk); #1;
    chk("stats_count", 32'(tx_count), 32'd5);
    @(negedge clk);
    cfg_load = 1'b1; cfg_div = 16'h0010;
    @(negedge clk);
    cfg_load = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("stats_after_cfg", 32'(tx_count), 32'd5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spart_tx_sched.md
Name: spart_tx_sched

Overview:
- Controller and round-robin arbiter in front of the SPART transmit datapath.
- Shares one transmitter between NREQ byte requesters.
- Programs the baud divisor registers at start-up and on request.
- Generates the transmitter's processor-side bus cycles (iocs/iorw/ioaddr/databus) and paces them on tbr.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DIV_DEFAULT, 16'd325, baud divisor written after reset.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-low (asserted when 0).
- req  input  NREQ  per-requester byte request, level; held until matching gnt.
- req_data  input  8*NREQ  requester i byte on bits [8i+7:8i].
- gnt  output  NREQ  one-cycle pulse: byte of requester i issued to transmitter.
- cfg_load  input  1  pulse: reprogram divisor with cfg_div.
- cfg_div  input  16  new divisor, sampled when cfg_load=1.
- cfg_busy  output  1  high while a divisor write is pending or in progress.
- tbr  input  1  transmit buffer ready from transmitter (1 = can accept byte).
- iocs  output  1  chip select to transmitter.
- iorw  output  1  1 = read/idle, 0 = write.
- ioaddr  output  2  0 = TX data, 2 = divisor low, 3 = divisor high.
- databus  output  8  write data.

Behaviour:
- All outputs registered.
- Reset (async, rst=0) values:
  - iocs=0, iorw=1, ioaddr=0, databus=0, gnt=0, cfg_busy=1.
  - FSM=CFG_LO, RR pointer=0, divisor latch=DIV_DEFAULT, pending-cfg=1.
- Reset mid-operation aborts any cycle immediately; divisor reprogrammed after release.
- Bus idle value whenever no write is issued: iocs=0, iorw=1, ioaddr=0, databus=0.
- Every write is exactly one cycle: iocs=1, iorw=0.
- FSM states: IDLE, CFG_LO, CFG_HI, WRITE, HOLD.
- IDLE:
  - If tbr=1 and pending-cfg=1 -> CFG_LO.
  - Else if tbr=1 and |req -> capture winner index and its byte -> WRITE.
  - Else stay.
  - Config has priority over data; divisor never changes while tbr=0.
- CFG_LO (first entry after reset does not wait for tbr): write divisor[7:0] to ioaddr=2 -> CFG_HI.
- CFG_HI: write divisor[15:8] to ioaddr=3; clear pending-cfg; cfg_busy=0 next cycle -> IDLE.
- WRITE:
  - Write captured byte to ioaddr=0.
  - gnt[winner]=1 this cycle only.
  - RR pointer <= (winner+1) mod NREQ -> HOLD.
- HOLD: one cycle, idle bus; covers the 1-cycle delay before tbr falls -> IDLE.
- Latency: req seen in IDLE with tbr=1 at cycle N -> iocs/gnt at N+1 -> IDLE again at N+3.
- Round robin:
  - Search starts at RR pointer, ascending index with wrap NREQ-1 -> 0.
  - The pointer index is highest priority.
- cfg_load:
  - Accepted in any state: divisor latch <= cfg_div, pending-cfg <= 1, cfg_busy <= 1.
  - cfg_load during CFG_LO/CFG_HI: new value latched; pending stays set; full LO/HI sequence repeats with new value.
- req dropped after capture: write and gnt still occur with the captured byte (protocol violation by requester, no error).
- Simultaneous cfg_load and req in IDLE with tbr=1: req is arbitrated this cycle; config follows at the next IDLE with tbr=1.

Optional Feature:
- Macro SPART_TX_STATS_EN.
- Defined:
  - Adds output tx_count[15:0], reset 0.
  - Increments by 1 in each WRITE cycle; wraps 16'hFFFF -> 0.
  - Not incremented by divisor writes.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Release reset, tbr=1, no req -> writes 8'h45 @ioaddr 2 then 8'h01 @ioaddr 3 on consecutive cycles; cfg_busy falls next cycle; bus idle afterwards.
- req=4'b0001, req_data[7:0]=8'hA5, tbr=1 -> one cycle iocs=1, iorw=0, ioaddr=0, databus=A5 with gnt=0001; tbr driven 0 after that cycle -> no further write until tbr=1.
- req=4'b1111 held, tbr pulsing ready after each byte -> gnt order 0001, 0010, 0100, 1000, 0001; no requester granted twice in a row.
- Transmitter busy (tbr=0), cfg_load with cfg_div=16'h0010 -> no divisor write until tbr=1; then 8'h10 @2, 8'h00 @3 issued before any pending data byte.
- rst=0 asynchronously during WRITE -> iocs=0, gnt=0 immediately; after release the DIV_DEFAULT sequence repeats and RR restarts at requester 0.
- With SPART_TX_STATS_EN: 65537 granted bytes -> tx_count=1; divisor writes do not change tx_count.
